// File: rtl/wb_stage.sv
// Write-back stage: retires MEM results into the register file and CSR file,
// commits exceptions/ERTN, sequences TLB operations and raises pipeline flushes.
module wb_stage #(
    parameter int ZIP_W       = 207,
    parameter int TLB_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              mem_to_wb_valid,
    input  logic [ZIP_W-1:0]  mem_to_wb_zip,
    output logic              wb_allowin,

    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    output logic [38:0]       wb_rf_zip,

    output logic              csr_re,
    output logic [13:0]       csr_num,
    input  logic [31:0]       csr_rvalue,
    output logic              csr_we,
    output logic [31:0]       csr_wmask,
    output logic [31:0]       csr_wvalue,

    output logic              wb_ex,
    output logic [5:0]        wb_ecode,
    output logic [8:0]        wb_esubcode,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_vaddr,
    output logic              ertn_flush,
    input  logic [31:0]       ex_entry,
    input  logic [31:0]       era,

    output logic              flush,
    output logic [31:0]       flush_pc,

    output logic              tlb_req,
    output logic [2:0]        tlb_op_o,
    output logic [4:0]        invtlb_op_o,
    input  logic              tlb_done,

    output logic              wb_ex_fwd,

    output logic [31:0]       debug_wb_pc,
    output logic [3:0]        debug_wb_rf_we,
    output logic [4:0]        debug_wb_rf_wnum,
    output logic [31:0]       debug_wb_rf_wdata
);

    // Field positions inside the MEM->WB bundle, counted from bit 0.
    localparam int INVTLB_LSB = 0;
    localparam int TLBOP_LSB  = 5;
    localparam int ERTN_BIT   = 8;
    localparam int ESUB_LSB   = 9;
    localparam int ECODE_LSB  = 18;
    localparam int EXV_BIT    = 24;
    localparam int VADDR_LSB  = 25;
    localparam int WVALUE_LSB = 57;
    localparam int WMASK_LSB  = 89;
    localparam int CSRNUM_LSB = 121;
    localparam int CSRWE_BIT  = 135;
    localparam int CSRRD_BIT  = 136;
    localparam int PC_LSB     = 137;
    localparam int WDATA_LSB  = 169;
    localparam int WADDR_LSB  = 201;
    localparam int RFWE_BIT   = 206;

    localparam int CNT_W = (TLB_TIMEOUT > 1) ? $clog2(TLB_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TLB_TIMEOUT > 0) ? TLB_TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE,
        TLB_WAIT
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tlb_cnt;
    logic             wb_valid;

    logic        rf_we_r;
    logic [4:0]  rf_waddr_r;
    logic [31:0] rf_wdata_r;
    logic [31:0] pc_r;
    logic        csr_read_r;
    logic        csr_we_r;
    logic [13:0] csr_num_r;
    logic [31:0] csr_wmask_r;
    logic [31:0] csr_wvalue_r;
    logic [31:0] vaddr_r;
    logic        ex_valid_r;
    logic [5:0]  ecode_r;
    logic [8:0]  esubcode_r;
    logic        is_ertn_r;
    logic [2:0]  tlb_op_r;
    logic [4:0]  invtlb_op_r;

    logic        wb_live;
    logic        tlb_op_active;
    logic        timeout_hit;
    logic        tlb_finish;
    logic        ready_go;
    logic        retire;
    logic        commit_ok;
    logic        refetch;
    logic        csr_refetch;
    logic [31:0] final_wdata;
    logic        load_zip;

    // Reset masks the held instruction so nothing commits while resetn is low.
    assign wb_live       = wb_valid & resetn;
    assign tlb_op_active = (tlb_op_r >= 3'd1) && (tlb_op_r <= 3'd5);
    assign timeout_hit   = (TLB_TIMEOUT != 0) && (state == TLB_WAIT) && (tlb_cnt == CNT_LAST);
    assign tlb_finish    = (state == TLB_WAIT) && (tlb_done || timeout_hit);
    assign ready_go      = ex_valid_r | is_ertn_r | ~tlb_op_active | tlb_finish;
    assign wb_allowin    = ~wb_live | ready_go;
    assign retire        = wb_live & ready_go;
    assign commit_ok     = retire & ~ex_valid_r & ~is_ertn_r;
    assign load_zip      = mem_to_wb_valid & wb_allowin & ~flush;

    // NOTE: control state uses non-blocking assignments so every flop samples
    // pre-edge values, independent of the order the blocks are evaluated.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
            tlb_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (flush)
                wb_valid <= 1'b0;
            else if (wb_allowin)
                wb_valid <= mem_to_wb_valid;
            if (state != TLB_WAIT)
                tlb_cnt <= '0;
            else if (TLB_TIMEOUT != 0 && !timeout_hit)
                tlb_cnt <= tlb_cnt + CNT_W'(1);
        end
    end

    // NOTE: payload registers are deliberately not reset; every consumer is
    // qualified by wb_valid, so their power-up contents are never observed.
    always_ff @(posedge clk) begin
        if (load_zip) begin
            rf_we_r      <= mem_to_wb_zip[RFWE_BIT];
            rf_waddr_r   <= mem_to_wb_zip[WADDR_LSB +: 5];
            rf_wdata_r   <= mem_to_wb_zip[WDATA_LSB +: 32];
            pc_r         <= mem_to_wb_zip[PC_LSB +: 32];
            csr_read_r   <= mem_to_wb_zip[CSRRD_BIT];
            csr_we_r     <= mem_to_wb_zip[CSRWE_BIT];
            csr_num_r    <= mem_to_wb_zip[CSRNUM_LSB +: 14];
            csr_wmask_r  <= mem_to_wb_zip[WMASK_LSB +: 32];
            csr_wvalue_r <= mem_to_wb_zip[WVALUE_LSB +: 32];
            vaddr_r      <= mem_to_wb_zip[VADDR_LSB +: 32];
            ex_valid_r   <= mem_to_wb_zip[EXV_BIT];
            ecode_r      <= mem_to_wb_zip[ECODE_LSB +: 6];
            esubcode_r   <= mem_to_wb_zip[ESUB_LSB +: 9];
            is_ertn_r    <= mem_to_wb_zip[ERTN_BIT];
            tlb_op_r     <= mem_to_wb_zip[TLBOP_LSB +: 3];
            invtlb_op_r  <= mem_to_wb_zip[INVTLB_LSB +: 5];
        end
    end

    // NOTE: the default assignment up front keeps this block latch-free.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (wb_live && tlb_op_active && !ex_valid_r && !is_ertn_r)
                          state_nxt = TLB_WAIT;
            TLB_WAIT: if (tlb_done || timeout_hit)
                          state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Writes to these CSRs change translation or interrupt state, so the
    // following instructions must be refetched.
    assign csr_refetch = csr_we_r && (csr_num_r == 14'h000 || csr_num_r == 14'h018 ||
                                      csr_num_r == 14'h180 || csr_num_r == 14'h181);
    assign refetch     = commit_ok & ((tlb_op_r >= 3'd3 && tlb_op_r <= 3'd5) | csr_refetch);

    assign final_wdata = csr_read_r ? csr_rvalue : rf_wdata_r;

    assign rf_we      = commit_ok & rf_we_r;
    assign rf_waddr   = rf_waddr_r;
    assign rf_wdata   = final_wdata;
    assign wb_rf_zip  = {wb_live & csr_read_r, wb_live & rf_we_r, rf_waddr_r, final_wdata};

    assign csr_re     = wb_live & csr_read_r;
    assign csr_num    = csr_num_r;
    assign csr_we     = commit_ok & csr_we_r;
    assign csr_wmask  = csr_wmask_r;
    assign csr_wvalue = csr_wvalue_r;

    assign wb_ex       = retire & ex_valid_r;
    assign wb_ecode    = ecode_r;
    assign wb_esubcode = esubcode_r;
    assign wb_pc       = pc_r;
    assign wb_vaddr    = vaddr_r;
    assign ertn_flush  = retire & is_ertn_r & ~ex_valid_r;

    assign flush    = wb_ex | ertn_flush | refetch;
    assign flush_pc = wb_ex ? ex_entry : (ertn_flush ? era : pc_r + 32'd4);

    assign tlb_req     = (state == TLB_WAIT);
    assign tlb_op_o    = tlb_op_r;
    assign invtlb_op_o = invtlb_op_r;

    assign wb_ex_fwd = wb_live & (ex_valid_r | is_ertn_r);

    assign debug_wb_pc       = pc_r;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = rf_waddr;
    assign debug_wb_rf_wdata = rf_wdata;

endmodule
